// File: rtl/key_schedule_seq_if.sv
// Key-load and round-key read bundle for the iterative AES key-schedule sequencer.
// key_in is packed with word 0 in the most significant 32 bits.
interface key_schedule_seq_if #(
    parameter int unsigned Nk = 4
);
    logic [32*Nk-1:0] key_in;
    logic             key_valid;
    logic             key_ready;
    logic             rk_req;
    logic [3:0]       rk_idx;
    logic             rk_ready;
    logic             rk_valid;
    logic [127:0]     rk_data;
    logic             sched_done;

    // Key source / round controller side
    modport master (
        output key_in, key_valid, rk_req, rk_idx,
        input  key_ready, rk_ready, rk_valid, rk_data, sched_done
    );

    // Key-schedule engine side
    modport slave (
        input  key_in, key_valid, rk_req, rk_idx,
        output key_ready, rk_ready, rk_valid, rk_data, sched_done
    );
endinterface

// File: rtl/key_schedule_seq.sv
// Iterative AES key expansion: one 32-bit word per cycle through a single SubWord unit,
// results held in a register store and read back as 128-bit round keys by index.
module key_schedule_seq #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input logic             clk,
    input logic             rst,
    key_schedule_seq_if.slave bus
);
    localparam int unsigned Nw = 4 * (Nr + 1);
    localparam int unsigned IW = $clog2(Nw);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExpand = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    localparam logic [3:0] NrIdx = 4'(Nr);

    logic [1:0]    state_q;
    logic [IW-1:0] i_q;
    logic [2:0]    mod_q;   // i % Nk
    logic [3:0]    rnd_q;   // i / Nk, only meaningful when mod_q == 0
    logic [31:0]   w_q [Nw];
    logic          rk_valid_q;
    logic [127:0]  rk_data_q;

    logic [31:0]   prev, back, sub_in, sub_out, temp, new_w;
    logic [IW-1:0] rd_base;
    logic [127:0]  rd_data;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            r = gmul(r, r);
            if (k != 0) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Next schedule word w[i] from w[i-1] and w[i-Nk] through the shared SubWord unit
    always_comb begin
        prev    = w_q[i_q - IW'(1)];
        back    = w_q[i_q - IW'(Nk)];
        sub_in  = (mod_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out = sub_word(sub_in);
        temp    = prev;
        if (mod_q == 3'd0) begin
            temp = sub_out ^ {rcon(rnd_q), 24'h000000};
        end else if ((Nk > 6) && (mod_q == 3'd4)) begin
            temp = sub_out;
        end
        new_w = back ^ temp;
    end

    // Round-key read mux; out-of-range indices read as zero
    always_comb begin
        rd_base = IW'({bus.rk_idx, 2'b00});
        rd_data = 128'h0;
        if (bus.rk_idx <= NrIdx) begin
            rd_data = {w_q[rd_base], w_q[rd_base + IW'(1)],
                       w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
        end
    end

    // Sequencer state, word counter, store writes and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            i_q        <= '0;
            mod_q      <= 3'd0;
            rnd_q      <= 4'd0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= 128'h0;
        end else begin
            // Reads use the store as it stands before this edge, so a same-edge
            // rekey still returns the old key's round key.
            rk_valid_q <= bus.rk_req && (state_q == StDone);
            if (bus.rk_req && (state_q == StDone)) begin
                rk_data_q <= rd_data;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (bus.key_valid) begin
                        for (int k = 0; k < Nk; k++) begin
                            w_q[IW'(k)] <= bus.key_in[32*(Nk-1-k) +: 32];
                        end
                        i_q     <= IW'(Nk);
                        mod_q   <= 3'd0;
                        rnd_q   <= 4'd1;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    w_q[i_q] <= new_w;
                    i_q      <= i_q + IW'(1);
                    if (mod_q == 3'(Nk - 1)) begin
                        mod_q <= 3'd0;
                        rnd_q <= rnd_q + 4'd1;
                    end else begin
                        mod_q <= mod_q + 3'd1;
                    end
                    if (i_q == IW'(Nw - 1)) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.key_ready  = (state_q != StExpand);
    assign bus.rk_ready   = (state_q == StDone);
    assign bus.sched_done = (state_q == StDone);
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_data    = rk_data_q;
endmodule
